// File: rtl/pipe_mdu_ctrl.sv
// rtl/pipe_mdu_ctrl.sv - multi-cycle multiply/divide sequencer with HI/LO ownership and EXE stall
module pipe_mdu_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             estart,
  input  logic [1:0]       eop,
  input  logic [WIDTH-1:0] ea,
  input  logic [WIDTH-1:0] eb,
  input  logic             ehi_rd,
  input  logic             elo_rd,
  input  logic             ewhi,
  input  logic             ewlo,
  input  logic [WIDTH-1:0] ewdata,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc_hi, acc_lo, opd;
  logic             is_div, neg_res, neg_rem;

  logic             sgn;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff;
  logic             no_borrow;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] quo_s, rem_s, res_hi, res_lo;

  assign sgn   = ~eop[0];
  assign a_mag = (sgn && ea[WIDTH-1]) ? -ea : ea;
  assign b_mag = (sgn && eb[WIDTH-1]) ? -eb : eb;

  // Multiply: acc_lo holds the multiplier and shifts out as product bits shift in.
  assign mul_sum = {1'b0, acc_hi} + ({(WIDTH+1){acc_lo[0]}} & {1'b0, opd});

  // Divide: acc_hi is the partial remainder, acc_lo the dividend shifting into quotient.
  assign rem_sh    = {acc_hi, acc_lo[WIDTH-1]};
  assign no_borrow = (rem_sh >= {1'b0, opd});
  assign rem_diff  = rem_sh[WIDTH-1:0] - opd;

  assign prod_s = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quo_s  = neg_res ? -acc_lo : acc_lo;
  assign rem_s  = neg_rem ? -acc_hi : acc_hi;
  assign res_hi = is_div ? rem_s : prod_s[2*WIDTH-1:WIDTH];
  assign res_lo = is_div ? quo_s : prod_s[WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    stall     = 1'b0;
    case (state)
      IDLE:    if (estart) state_nxt = RUN;
      RUN:     if (count == CNT_W'(WIDTH-1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Gated by reset so an abort drops the stall in the very cycle reset is seen.
    busy  = (state != IDLE) && !reset;
    done  = (state == FIX) && !reset;
    stall = busy && (estart || ehi_rd || elo_rd || ewhi || ewlo);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opd     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ewhi) hi <= ewdata;
          if (ewlo) lo <= ewdata;
          if (estart) begin
            count   <= '0;
            acc_hi  <= '0;
            acc_lo  <= eop[1] ? a_mag : b_mag;
            opd     <= eop[1] ? b_mag : a_mag;
            is_div  <= eop[1];
            neg_res <= sgn && (ea[WIDTH-1] ^ eb[WIDTH-1]);
            neg_rem <= sgn && ea[WIDTH-1];
          end
        end
        RUN: begin
          count <= count + CNT_W'(1);
          if (is_div) begin
            acc_hi <= no_borrow ? rem_diff : rem_sh[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], no_borrow};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          hi <= res_hi;
          lo <= res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_mdu_ctrl.sv
// tb/tb_pipe_mdu_ctrl.sv - directed self-checking bench for pipe_mdu_ctrl
module tb_pipe_mdu_ctrl;

  logic        clock = 1'b0;
  logic        reset, estart, ehi_rd, elo_rd, ewhi, ewlo;
  logic [1:0]  eop;
  logic [31:0] ea, eb, ewdata;
  logic        stall, busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pipe_mdu_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .estart(estart), .eop(eop), .ea(ea), .eb(eb),
    .ehi_rd(ehi_rd), .elo_rd(elo_rd), .ewhi(ewhi), .ewlo(ewlo), .ewdata(ewdata),
    .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Called at a negedge in cycle t; returns at the negedge of cycle t+1.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    estart = 1'b1; eop = op; ea = a; eb = b;
    @(negedge clock);
    estart = 1'b0;
  endtask

  // Starts in cycle t+1 (i=1); records first done cycle, pulse count and hi/lo/busy at t+34.
  task automatic wait_done(output int dcyc, output int pulses,
                           output logic [31:0] h, output logic [31:0] l, output logic bz);
    dcyc = -1; pulses = 0; h = 'x; l = 'x; bz = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin
        pulses++;
        if (dcyc < 0) dcyc = i;
      end
      if (i == 34) begin h = hi; l = lo; bz = busy; end
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; estart = 1'b1; eop = 2'b01; ea = 32'd3; eb = 32'd4;
    ehi_rd = 1'b0; elo_rd = 1'b0; ewhi = 1'b0; ewlo = 1'b0; ewdata = '0;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, done, stall} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 000", {busy, done, stall});
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL reset_hilo got %h/%h exp 0/0", hi, lo);
    end
    estart = 1'b0; reset = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %b exp 0", busy); end
  endtask

  task automatic test_multu_latency;
    int dc, np; logic [31:0] h, l; logic bz;
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL multu_busy got %b exp 1", busy); end
    wait_done(dc, np, h, l, bz);
    checks++;
    if (dc !== 33) begin errors++; $display("FAIL multu_done_cycle got %0d exp 33", dc); end
    checks++;
    if (np !== 1) begin errors++; $display("FAIL multu_done_pulses got %0d exp 1", np); end
    checks++;
    if (h !== 32'hFFFF_FFFE || l !== 32'h0000_0001) begin
      errors++; $display("FAIL multu_result got %h/%h exp fffffffe/00000001", h, l);
    end
    checks++;
    if (bz !== 1'b0) begin errors++; $display("FAIL multu_idle_after got %b exp 0", bz); end
  endtask

  task automatic test_arith;
    logic [1:0]  t_op [8];
    logic [31:0] t_a [8], t_b [8], t_hi [8], t_lo [8];
    int dc, np; logic [31:0] h, l; logic bz;
    t_op[0] = 2'b00; t_a[0] = 32'hFFFF_FFF9; t_b[0] = 32'd3;          t_hi[0] = 32'hFFFF_FFFF; t_lo[0] = 32'hFFFF_FFEB;
    t_op[1] = 2'b10; t_a[1] = 32'hFFFF_FFF9; t_b[1] = 32'd2;          t_hi[1] = 32'hFFFF_FFFF; t_lo[1] = 32'hFFFF_FFFD;
    t_op[2] = 2'b11; t_a[2] = 32'd100;       t_b[2] = 32'd0;          t_hi[2] = 32'd100;       t_lo[2] = 32'hFFFF_FFFF;
    t_op[3] = 2'b10; t_a[3] = 32'h8000_0000; t_b[3] = 32'hFFFF_FFFF;  t_hi[3] = 32'd0;         t_lo[3] = 32'h8000_0000;
    t_op[4] = 2'b10; t_a[4] = 32'hFFFF_FFF9; t_b[4] = 32'd0;          t_hi[4] = 32'hFFFF_FFF9; t_lo[4] = 32'd1;
    t_op[5] = 2'b11; t_a[5] = 32'd100;       t_b[5] = 32'd7;          t_hi[5] = 32'd2;         t_lo[5] = 32'd14;
    t_op[6] = 2'b00; t_a[6] = 32'h8000_0000; t_b[6] = 32'd2;          t_hi[6] = 32'hFFFF_FFFF; t_lo[6] = 32'd0;
    t_op[7] = 2'b10; t_a[7] = 32'd7;         t_b[7] = 32'hFFFF_FFFE;  t_hi[7] = 32'd1;         t_lo[7] = 32'hFFFF_FFFD;
    for (int k = 0; k < 8; k++) begin
      issue(t_op[k], t_a[k], t_b[k]);
      wait_done(dc, np, h, l, bz);
      checks++;
      if (dc !== 33 || np !== 1) begin
        errors++; $display("FAIL arith%0d_done got cycle %0d pulses %0d exp 33/1", k, dc, np);
      end
      checks++;
      if (h !== t_hi[k] || l !== t_lo[k]) begin
        errors++; $display("FAIL arith%0d_result got %h/%h exp %h/%h", k, h, l, t_hi[k], t_lo[k]);
      end
    end
  endtask

  task automatic test_mflo_stall;
    int rel = -1, n = 0;
    issue(2'b01, 32'd6, 32'd7);
    repeat (4) @(negedge clock);
    elo_rd = 1'b1;
    for (int i = 5; i <= 45; i++) begin
      #1;
      if (!stall) begin rel = i; break; end
      n++;
      @(negedge clock);
    end
    checks++;
    if (rel !== 34 || n !== 29) begin
      errors++; $display("FAIL mflo_stall got release %0d stalled %0d exp 34/29", rel, n);
    end
    checks++;
    if (lo !== 32'd42) begin errors++; $display("FAIL mflo_value got %h exp 0000002a", lo); end
    @(negedge clock);
    elo_rd = 1'b0;
  endtask

  task automatic test_mthi_idle;
    ewhi = 1'b1; ewdata = 32'h0000_1234;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL mthi_idle_stall got %b exp 0", stall); end
    @(negedge clock);
    ewhi = 1'b0; ewlo = 1'b1; ewdata = 32'h0000_5678;
    checks++;
    if (hi !== 32'h0000_1234) begin errors++; $display("FAIL mthi_idle_value got %h exp 00001234", hi); end
    @(negedge clock);
    ewlo = 1'b0;
    checks++;
    if (lo !== 32'h0000_5678 || hi !== 32'h0000_1234) begin
      errors++; $display("FAIL mtlo_idle_value got %h/%h exp 00001234/00005678", hi, lo);
    end
  endtask

  task automatic test_mthi_during_run;
    int rel = -1, n = 0;
    issue(2'b01, 32'd2, 32'd3);
    repeat (2) @(negedge clock);
    ewhi = 1'b1; ewdata = 32'h0000_ABCD;
    for (int i = 3; i <= 45; i++) begin
      #1;
      if (!stall) begin rel = i; break; end
      n++;
      @(negedge clock);
    end
    checks++;
    if (rel !== 34 || n !== 31) begin
      errors++; $display("FAIL mthi_run_stall got release %0d stalled %0d exp 34/31", rel, n);
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd6) begin
      errors++; $display("FAIL mthi_run_result got %h/%h exp 0/6", hi, lo);
    end
    @(negedge clock);
    ewhi = 1'b0;
    checks++;
    if (hi !== 32'h0000_ABCD) begin errors++; $display("FAIL mthi_run_write got %h exp 0000abcd", hi); end
  endtask

  task automatic test_mthi_with_start;
    int dc, np; logic [31:0] h, l; logic bz;
    ewhi = 1'b1; ewdata = 32'h0000_5555;
    estart = 1'b1; eop = 2'b01; ea = 32'd2; eb = 32'd3;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL issue_stall got %b exp 0", stall); end
    @(negedge clock);
    estart = 1'b0; ewhi = 1'b0;
    checks++;
    if (hi !== 32'h0000_5555) begin errors++; $display("FAIL mthi_start_write got %h exp 00005555", hi); end
    wait_done(dc, np, h, l, bz);
    checks++;
    if (h !== 32'd0 || l !== 32'd6) begin
      errors++; $display("FAIL mthi_start_overwrite got %h/%h exp 0/6", h, l);
    end
  endtask

  task automatic test_back_to_back;
    int rel = -1, dc, np; logic [31:0] h, l; logic bz;
    estart = 1'b1; eop = 2'b11; ea = 32'd100; eb = 32'd7;
    @(negedge clock);
    eop = 2'b01; ea = 32'd5; eb = 32'd5;
    for (int i = 1; i <= 45; i++) begin
      #1;
      if (!stall) begin rel = i; break; end
      @(negedge clock);
    end
    checks++;
    if (rel !== 34) begin errors++; $display("FAIL b2b_release got %0d exp 34", rel); end
    checks++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      errors++; $display("FAIL b2b_first got %h/%h exp 2/e", hi, lo);
    end
    @(negedge clock);
    estart = 1'b0;
    wait_done(dc, np, h, l, bz);
    checks++;
    if (dc !== 33 || h !== 32'd0 || l !== 32'd25) begin
      errors++; $display("FAIL b2b_second got cycle %0d %h/%h exp 33 0/19", dc, h, l);
    end
  endtask

  task automatic test_reset_mid;
    int np = 0;
    ewhi = 1'b1; ewlo = 1'b1; ewdata = 32'h0000_0077;
    @(negedge clock);
    ewhi = 1'b0; ewlo = 1'b0;
    issue(2'b10, 32'd1000, 32'd7);
    repeat (10) @(negedge clock);
    reset = 1'b1; elo_rd = 1'b1;
    #1;
    checks++;
    if ({busy, stall, done} !== 3'b000) begin
      errors++; $display("FAIL reset_mid_same got %b exp 000", {busy, stall, done});
    end
    @(negedge clock);
    reset = 1'b0; elo_rd = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL reset_mid_after got busy %b %h/%h exp 0 0/0", busy, hi, lo);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done) np++;
    end
    checks++;
    if (np !== 0) begin errors++; $display("FAIL reset_mid_done got %0d exp 0", np); end
  endtask

  initial begin
    @(negedge clock);
    test_reset;
    test_multu_latency;
    test_arith;
    test_mflo_stall;
    test_mthi_idle;
    test_mthi_during_run;
    test_mthi_with_start;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
